ib_ram_update_ctrl: RTL and testbench

//  Iteration-update sequencer for the shared IB-VNU LUT RAM (two-bank, two-half multi-frame page store).

---
 rtl/ib_ctrl_pkg.sv | 20 ++
 rtl/ib_ram_update_ctrl_if.sv | 23 ++
 rtl/ib_ram_wr_port.sv | 31 +++
 rtl/ib_ram_update_ctrl.sv | 123 ++++++++++++
 tb/tb_ib_ram_update_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ib_ctrl_pkg.sv
// Shared types and constants for the IB-VNU LUT RAM update controller and its LUT loaders.
package ib_ctrl_pkg;

  localparam int ENTRY_ADDR_DEF = 7;
  localparam int LUT_W_DEF      = 8;
  localparam int PAGES_PER_HALF = 2 ** (ENTRY_ADDR_DEF - 1);
  localparam int ITER_CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } ctrl_state_e;

  function automatic logic [ITER_CNT_W-1:0] sat_inc(input logic [ITER_CNT_W-1:0] v,
                                                   input logic [ITER_CNT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ib_ram_update_ctrl_if.sv
// Upstream LUT page stream plus the RAM write/read-half bus fanned out to the VNU datapaths.
interface ib_ram_update_ctrl_if #(
  parameter int ENTRY_ADDR = 7,
  parameter int LUT_W      = 8
);
  logic                  lut_valid;
  logic                  lut_ready;
  logic [LUT_W-1:0]      lut_data;
  logic [ENTRY_ADDR-1:0] page_addr_ram;
  logic [LUT_W-1:0]      ram_write_data_0;
  logic                  ib_ram_we;
  logic                  read_addr_offset;

  modport master (
    input  lut_valid, lut_data,
    output lut_ready, page_addr_ram, ram_write_data_0, ib_ram_we, read_addr_offset
  );

  modport slave (
    output lut_valid, lut_data,
    input  lut_ready, page_addr_ram, ram_write_data_0, ib_ram_we, read_addr_offset
  );
endinterface

// File: rtl/ib_ram_wr_port.sv
// One-cycle registered RAM write stage (address, data, strobe); shared with the f1 LUT loaders.
module ib_ram_wr_port #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_p0,
  input  logic [ADDR_W-1:0] addr_p0,
  input  logic [DATA_W-1:0] data_p0,
  output logic [ADDR_W-1:0] addr_p1,
  output logic [DATA_W-1:0] data_p1,
  output logic              we_p1
);

  // p0 -> p1: handshake registered into the RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      we_p1 <= wr_en_p0;
      if (wr_en_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

endmodule

// File: rtl/ib_ram_update_ctrl.sv
// Loads one iteration's LUT pages into the idle RAM half, then swaps the read half at an iteration boundary.
module ib_ram_update_ctrl
  import ib_ctrl_pkg::*;
#(
  parameter int QUAN_SIZE     = 4,
  parameter int ENTRY_ADDR    = 7,
  parameter int BANK_NUM      = 2,
  parameter int LUT_PORT_SIZE = 4,
  parameter int ITER_MAX      = 20
) (
  input  logic                  write_clk,
  input  logic                  rst,
  input  logic                  iter_start,
  input  logic                  abort,
  input  logic                  codeword_start,
  input  logic                  iter_boundary,
  ib_ram_update_ctrl_if.master  bus,
  output logic                  busy,
  output logic                  update_done,
  output logic                  start_err,
  output logic [ITER_CNT_W-1:0] iter_cnt
);

  localparam int                    LUT_W     = LUT_PORT_SIZE * BANK_NUM;
  localparam int                    PAGE_W    = ENTRY_ADDR - 1;
  localparam logic [PAGE_W-1:0]     LAST_PAGE = '1;
  localparam logic [ITER_CNT_W-1:0] ITER_LIM  = ITER_CNT_W'(ITER_MAX);

  generate
    if (QUAN_SIZE < 1 || LUT_PORT_SIZE < 1) begin : g_param_chk
      $error("ib_ram_update_ctrl: QUAN_SIZE and LUT_PORT_SIZE must be positive");
    end
  endgenerate

  ctrl_state_e           state, state_nxt;
  logic [PAGE_W-1:0]     page_cnt;
  logic                  rd_half;
  logic                  hs_p0, start_ok, start_bad, swap;
  logic [ITER_CNT_W-1:0] cnt_eff;
  logic [ENTRY_ADDR-1:0] addr_p1;
  logic [LUT_W-1:0]      data_p1;
  logic                  we_p1;

  always_comb begin
    state_nxt = state;
    hs_p0     = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    swap      = 1'b0;
    cnt_eff   = codeword_start ? '0 : iter_cnt;
    unique case (state)
      IDLE: begin
        if (iter_start) begin
          if (cnt_eff < ITER_LIM) begin
            start_ok  = 1'b1;
            state_nxt = LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        hs_p0     = bus.lut_valid;
        start_bad = iter_start;
        if (abort)                               state_nxt = IDLE;
        else if (hs_p0 && page_cnt == LAST_PAGE) state_nxt = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        start_bad = iter_start;
        // a boundary in the cycle the last page is still being written is not a safe swap point
        if (abort) begin
          state_nxt = IDLE;
        end else if (iter_boundary && !we_p1) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state       <= IDLE;
      page_cnt    <= '0;
      rd_half     <= 1'b0;
      iter_cnt    <= '0;
      update_done <= 1'b0;
      start_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      update_done <= swap;
      start_err   <= start_bad;
      if (start_ok)                             page_cnt <= '0;
      else if (hs_p0 && page_cnt != LAST_PAGE)  page_cnt <= page_cnt + 1'b1;
      if (swap) rd_half <= ~rd_half;
      if (codeword_start) iter_cnt <= '0;
      else if (swap)      iter_cnt <= sat_inc(iter_cnt, ITER_LIM);
    end
  end

  ib_ram_wr_port #(
    .ADDR_W (ENTRY_ADDR),
    .DATA_W (LUT_W)
  ) u_wr_port (
    .clk      (write_clk),
    .rst      (rst),
    .wr_en_p0 (hs_p0),
    .addr_p0  ({~rd_half, page_cnt}),
    .data_p0  (bus.lut_data),
    .addr_p1  (addr_p1),
    .data_p1  (data_p1),
    .we_p1    (we_p1)
  );

  assign bus.lut_ready        = (state == LOAD);
  assign bus.page_addr_ram    = addr_p1;
  assign bus.ram_write_data_0 = data_p1;
  assign bus.ib_ram_we        = we_p1;
  assign bus.read_addr_offset = rd_half;
  assign busy                 = (state != IDLE);

endmodule

// File: tb/tb_ib_ram_update_ctrl.sv
// Randomized bench for ib_ram_update_ctrl against a transaction-level model of the update sequence.
module tb_ib_ram_update_ctrl;
  import ib_ctrl_pkg::*;

  logic clk = 1'b0, rst = 1'b0;
  logic iter_start = 1'b0, abort = 1'b0, codeword_start = 1'b0, iter_boundary = 1'b0;
  logic busy, update_done, start_err;
  logic [ITER_CNT_W-1:0] iter_cnt;

  ib_ram_update_ctrl_if #(.ENTRY_ADDR(7), .LUT_W(8)) bus ();

  ib_ram_update_ctrl dut (
    .write_clk      (clk),
    .rst            (rst),
    .iter_start     (iter_start),
    .abort          (abort),
    .codeword_start (codeword_start),
    .iter_boundary  (iter_boundary),
    .bus            (bus),
    .busy           (busy),
    .update_done    (update_done),
    .start_err      (start_err),
    .iter_cnt       (iter_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model: loading/waiting phase, pages accepted, read half, completed updates
  bit m_loading = 0, m_waiting = 0, m_half = 0, m_prev_we = 0;
  int m_pages = 0, m_cnt = 0, wr_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit st, input bit ab, input bit cw, input bit bd,
                     input bit vl, input logic [7:0] d);
    bit hs, swap, idle, acc;
    int eff;
    logic [6:0] exp_addr;
    iter_start = st; abort = ab; codeword_start = cw; iter_boundary = bd;
    bus.lut_valid = vl; bus.lut_data = d;
    chk("lut_ready", bus.lut_ready, m_loading);
    idle     = !m_loading && !m_waiting;
    eff      = cw ? 0 : m_cnt;
    hs       = m_loading && vl;
    acc      = st && idle && (eff < 20);
    swap     = m_waiting && !ab && bd && !m_prev_we;
    exp_addr = {~m_half, m_pages[5:0]};
    @(posedge clk); #1;
    chk("ib_ram_we", bus.ib_ram_we, hs);
    if (hs) begin
      chk("page_addr", bus.page_addr_ram, exp_addr);
      chk("wr_data", bus.ram_write_data_0, d);
      wr_total++;
    end
    chk("update_done", update_done, swap);
    chk("start_err", start_err, st && !acc);
    if (idle) begin
      if (acc) begin m_loading = 1; m_pages = 0; end
    end else if (m_loading) begin
      if (ab) m_loading = 0;
      else if (hs) begin
        if (m_pages == 63) begin m_loading = 0; m_waiting = 1; end
        else m_pages++;
      end
    end else begin
      if (ab) m_waiting = 0;
      else if (swap) begin m_waiting = 0; m_half = !m_half; end
    end
    if (cw) m_cnt = 0;
    else if (swap && m_cnt < 20) m_cnt++;
    m_prev_we = hs;
    chk("read_addr_offset", bus.read_addr_offset, m_half);
    chk("busy", busy, m_loading || m_waiting);
    chk("iter_cnt", iter_cnt, m_cnt);
  endtask

  task automatic do_rst(input bit vl);
    rst = 1; iter_start = 0; abort = 0; codeword_start = 0; iter_boundary = 0;
    bus.lut_valid = vl; bus.lut_data = 8'hA5;
    @(posedge clk); #1;
    chk("rst_we", bus.ib_ram_we, 0);
    chk("rst_addr", bus.page_addr_ram, 0);
    chk("rst_data", bus.ram_write_data_0, 0);
    chk("rst_rao", bus.read_addr_offset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_err", start_err, 0);
    chk("rst_cnt", iter_cnt, 0);
    chk("rst_ready", bus.lut_ready, 0);
    rst = 0;
    m_loading = 0; m_waiting = 0; m_half = 0; m_prev_we = 0; m_pages = 0; m_cnt = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'h00);
  endtask

  // starts a load and streams pages until the model leaves LOAD; gap is the % of idle valid cycles
  task automatic load_pages(input int gap, input int max_pages, input bit busy_start);
    int n = 0;
    cyc(1, 0, 0, 0, 0, 8'h00);
    while (m_loading && m_pages < max_pages && n < 2000) begin
      bit vl;
      vl = ($urandom_range(99) >= gap);
      cyc(busy_start && (n == 5), 0, 0, 0, vl, (gap == 0) ? 8'(m_pages) : 8'($urandom));
      n++;
    end
    if (n >= 2000) chk("load_timeout", n, 0);
  endtask

  int w0;
  bit h0;

  initial begin
    bus.lut_valid = 0; bus.lut_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_rst(0);

    // T1: full back-to-back load into half 1, then swap
    w0 = wr_total;
    load_pages(0, 64, 0);
    chk("t1_writes", wr_total - w0, 64);
    idle_cycles(2);
    cyc(0, 0, 0, 1, 0, 8'h00);
    chk("t1_rao", bus.read_addr_offset, 1);
    chk("t1_done", update_done, 1);

    // T2: second load into half 0; boundary while last write is in flight is ignored
    load_pages(0, 64, 0);
    cyc(0, 0, 0, 1, 0, 8'h00);
    chk("t2_early_bnd", busy, 1);
    cyc(0, 0, 0, 1, 0, 8'h00);
    chk("t2_rao", bus.read_addr_offset, 0);
    chk("t2_cnt", iter_cnt, 2);

    // T3: 50% valid gaps, with an iter_start while busy
    w0 = wr_total;
    load_pages(50, 64, 1);
    chk("t3_writes", wr_total - w0, 64);
    idle_cycles($urandom_range(3));
    cyc(0, 0, 0, 1, 0, 8'h00);

    // T4: abort after page 10
    h0 = bus.read_addr_offset;
    w0 = wr_total;
    load_pages(0, 10, 0);
    cyc(0, 1, 0, 0, 1, 8'(m_pages));
    idle_cycles(2);
    chk("t4_writes", wr_total - w0, 11);
    chk("t4_busy", busy, 0);
    chk("t4_rao", bus.read_addr_offset, h0);
    load_pages(0, 64, 0);
    idle_cycles(1);
    cyc(0, 0, 0, 1, 0, 8'h00);

    // T5: exhaust ITER_MAX, then codeword_start re-enables
    cyc(0, 0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      load_pages(30, 64, 0);
      idle_cycles(1);
      cyc(0, 0, 0, 1, 0, 8'h00);
    end
    chk("t5_cnt", iter_cnt, 20);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("t5_refused", start_err, 1);
    chk("t5_no_load", busy, 0);
    cyc(1, 0, 1, 0, 0, 8'h00);
    chk("t5_accepted", busy, 1);
    chk("t5_cleared", iter_cnt, 0);
    cyc(0, 1, 0, 0, 0, 8'h00);

    // T6: rst mid-load, then abort coincident with boundary in WAIT_SWAP
    load_pages(0, 30, 0);
    do_rst(1);
    load_pages(0, 64, 0);
    idle_cycles(1);
    cyc(0, 1, 0, 1, 0, 8'h00);
    chk("t6_no_swap", bus.read_addr_offset, 0);
    chk("t6_idle", busy, 0);

    // random mix of all control pulses
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(99) < 4, $urandom_range(99) < 1, $urandom_range(99) < 2,
          $urandom_range(99) < 20, $urandom_range(99) < 75, 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
